// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline. It drives
//   the per-stage enables and pipeline-register flushes in the same cycle as
//   the hazard is seen, so there is no added latency. It handles these cases:
//     - load-use     : bubble into Execute, hold Fetch/Decode for one cycle
//     - taken branch : squash the wrong-path instructions in Decode/Execute
//     - multi-cycle  : hold the front end while a mul/div runs MD_CYCLES cycles
//     - mem_stall    : freeze every stage until data memory is ready
//   It also counts the cycles in which Fetch was held (enF=0).
//
// Parameters
//   MD_CYCLES  front-end stall cycles per multi-cycle op (2..32)
//   CNT_W      width of the stall_cycles counter
//
// Ports
//   clk, reset              single clock; synchronous active-high reset
//   rs1D, rs2D              source registers of the instruction in Decode
//   rdE, memreadE           destination register / load flag in Execute
//   pcsrcE                  taken branch or jump resolved in Execute
//   md_startE               multi-cycle op in Execute
//   mem_stall               data memory not ready
//   enF..enW                stage enables
//   flushD, flushE, flushM  synchronous clears for the D/E/M registers
//   md_busy, md_done        multi-cycle op in progress / release pulse
//   stall_cycles            saturating count of cycles with enF=0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdE,
  input  logic             memreadE,
  input  logic             pcsrcE,
  input  logic             md_startE,
  input  logic             mem_stall,
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             enW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // Down-counter just wide enough to hold MD_CYCLES-1.
  localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             load_use;

  // The load result is not ready until after Memory. Register x0 is
  // hard-wired to zero, so a load that targets x0 creates no dependency.
  assign load_use = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  // NOTE: every signal written here gets a default first. A path that
  // leaves a signal unassigned would make synthesis infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enF     = 1'b1;
    enD     = 1'b1;
    enE     = 1'b1;
    enM     = 1'b1;
    enW     = 1'b1;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    md_busy = 1'b0;
    md_done = 1'b0;

    if (reset) begin
      // Pass-through controls while in reset. The flops reload in always_ff.
      state_d = RUN;
      cnt_d   = '0;
    end else if (mem_stall) begin
      // Full freeze. State and cnt keep their values.
      enF     = 1'b0;
      enD     = 1'b0;
      enE     = 1'b0;
      enM     = 1'b0;
      enW     = 1'b0;
      md_busy = (state_q == BUSY);
    end else begin
      unique case (state_q)
        RUN: begin
          // md_startE wins over pcsrcE, and pcsrcE wins over load-use.
          if (md_startE) begin
            enF     = 1'b0;
            enD     = 1'b0;
            enE     = 1'b0;
            flushM  = 1'b1;
            state_d = BUSY;
            cnt_d   = CW'(MD_CYCLES - 1);
          end else if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (load_use) begin
            enF    = 1'b0;
            enD    = 1'b0;
            flushE = 1'b1;
          end
        end
        BUSY: begin
          md_busy = 1'b1;
          if (cnt_q != '0) begin
            enF    = 1'b0;
            enD    = 1'b0;
            enE    = 1'b0;
            flushM = 1'b1;
            cnt_d  = cnt_q - CW'(1);
          end else begin
            // Release cycle. A md_startE still held high is ignored here.
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // The counter stops at all-ones instead of wrapping back to zero.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!enF && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. It uses two instances that share
//   the same inputs:
//     dut_a : MD_CYCLES=8, CNT_W=16 (main checks)
//     dut_b : MD_CYCLES=8, CNT_W=4  (stall_cycles saturation)
//   Each cycle's controls are packed as
//   {enF,enD,enE,enM,enW,flushD,flushE,flushM,md_busy,md_done} and compared
//   with hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1D, rs2D, rdE;
  logic        memreadE, pcsrcE, md_startE, mem_stall;

  logic        a_enF, a_enD, a_enE, a_enM, a_enW;
  logic        a_flushD, a_flushE, a_flushM, a_md_busy, a_md_done;
  logic [15:0] a_stall_cycles;
  logic        b_enF, b_enD, b_enE, b_enM, b_enW;
  logic        b_flushD, b_flushE, b_flushM, b_md_busy, b_md_done;
  logic [3:0]  b_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected control vectors {en[F..W], flush[D,E,M], md_busy, md_done}.
  localparam logic [9:0] C_DEF  = 10'b11111_000_00;
  localparam logic [9:0] C_LU   = 10'b00111_010_00;
  localparam logic [9:0] C_BR   = 10'b11111_110_00;
  localparam logic [9:0] C_MDS  = 10'b00011_001_00;
  localparam logic [9:0] C_BSY  = 10'b00011_001_10;
  localparam logic [9:0] C_REL  = 10'b11111_000_11;
  localparam logic [9:0] C_MSR  = 10'b00000_000_00;
  localparam logic [9:0] C_MSB  = 10'b00000_000_10;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_CYCLES(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
    .memreadE(memreadE), .pcsrcE(pcsrcE), .md_startE(md_startE),
    .mem_stall(mem_stall),
    .enF(a_enF), .enD(a_enD), .enE(a_enE), .enM(a_enM), .enW(a_enW),
    .flushD(a_flushD), .flushE(a_flushE), .flushM(a_flushM),
    .md_busy(a_md_busy), .md_done(a_md_done), .stall_cycles(a_stall_cycles)
  );

  pipeline_hazard_ctrl #(.MD_CYCLES(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
    .memreadE(memreadE), .pcsrcE(pcsrcE), .md_startE(md_startE),
    .mem_stall(mem_stall),
    .enF(b_enF), .enD(b_enD), .enE(b_enE), .enM(b_enM), .enW(b_enW),
    .flushD(b_flushD), .flushE(b_flushE), .flushM(b_flushM),
    .md_busy(b_md_busy), .md_done(b_md_done), .stall_cycles(b_stall_cycles)
  );

  wire [9:0] ctl_a = {a_enF, a_enD, a_enE, a_enM, a_enW,
                      a_flushD, a_flushE, a_flushM, a_md_busy, a_md_done};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle's inputs, then wait for the combinational outputs to settle.
  task automatic drive(input logic rst, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic mr, input logic pc,
                       input logic mds, input logic ms);
    reset = rst; rdE = rd; rs1D = r1; rs2D = r2;
    memreadE = mr; pcsrcE = pc; md_startE = mds; mem_stall = ms;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected sequence for a multi-cycle op with 3 cycles of mem_stall:
  // start, 3 BUSY, 3 frozen, 4 BUSY, release.
  logic [9:0] ms_exp [12];
  logic       ms_in  [12];

  initial begin
    int dones;
    ms_exp = '{C_MDS, C_BSY, C_BSY, C_BSY, C_MSB, C_MSB, C_MSB,
               C_BSY, C_BSY, C_BSY, C_BSY, C_REL};
    ms_in  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset: controls pass through even when every event input is active.
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_ctl", 32'(ctl_a), 32'(C_DEF));
    tick();
    idle();
    check("post_reset_ctl", 32'(ctl_a), 32'(C_DEF));
    check("post_reset_cnt", 32'(a_stall_cycles), 32'd0);
    check("post_reset_cnt_b", 32'(b_stall_cycles), 32'd0);

    // Load-use through rs1D, for one cycle only.
    drive(1'b0, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs1_ctl", 32'(ctl_a), 32'(C_LU));
    tick();
    idle();
    check("lu_after_ctl", 32'(ctl_a), 32'(C_DEF));
    check("lu_cnt", 32'(a_stall_cycles), 32'd1);
    // A load into x0 creates no dependency.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_x0_ctl", 32'(ctl_a), 32'(C_DEF));
    tick();
    check("lu_x0_cnt", 32'(a_stall_cycles), 32'd1);
    // Load-use through rs2D.
    drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs2_ctl", 32'(ctl_a), 32'(C_LU));
    tick();
    check("lu_rs2_cnt", 32'(a_stall_cycles), 32'd2);
    // Register match, but the instruction in Execute is not a load.
    drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    check("no_load_ctl", 32'(ctl_a), 32'(C_DEF));
    tick();

    // A branch outranks a load-use in the same cycle.
    drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br_lu_ctl", 32'(ctl_a), 32'(C_BR));
    tick();
    check("br_cnt", 32'(a_stall_cycles), 32'd2);
    // md_startE outranks a branch.
    drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("md_over_br_ctl", 32'(ctl_a), 32'(C_MDS));

    // Multi-cycle op with md_startE held high, including the release cycle.
    dones = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("md_cyc%0d", i), 32'(ctl_a),
            32'((i == 1) ? C_MDS : (i == 9) ? C_REL : C_BSY));
      dones += int'(a_md_done);
      tick();
    end
    idle();
    check("md_done_pulses", 32'(dones), 32'd1);
    check("md_cnt", 32'(a_stall_cycles), 32'd10);
    check("md_after_ctl", 32'(ctl_a), 32'(C_DEF));
    tick();

    // Three cycles of mem_stall in the middle of BUSY delay the release by 3.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i == 0), ms_in[i]);
      check($sformatf("ms_cyc%0d", i), 32'(ctl_a), 32'(ms_exp[i]));
      tick();
    end
    idle();
    check("ms_cnt", 32'(a_stall_cycles), 32'd21);

    // md_startE under mem_stall waits; the start is taken once mem_stall drops.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("md_ms_run_ctl", 32'(ctl_a), 32'(C_MSR));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("md_ms_start_ctl", 32'(ctl_a), 32'(C_MDS));
    tick();
    idle();
    check("rst_busy_c2", 32'(ctl_a), 32'(C_BSY));
    tick();
    check("rst_busy_c3", 32'(ctl_a), 32'(C_BSY));
    tick();
    // Reset in cycle 4 of the op aborts it.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_busy_ctl", 32'(ctl_a), 32'(C_DEF));
    tick();
    idle();
    check("rst_after_ctl", 32'(ctl_a), 32'(C_DEF));
    check("rst_after_cnt", 32'(a_stall_cycles), 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += int'(a_md_done) + int'(a_md_busy);
      tick();
    end
    check("rst_no_done", 32'(dones), 32'd0);

    // 20 consecutive stall cycles: the 4-bit counter stops at 4'hF.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle();
    check("sat_cnt_b", 32'(b_stall_cycles), 32'hF);
    check("sat_cnt_a", 32'(a_stall_cycles), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 8, legal 2..32: number of stall cycles a multi-cycle execute op holds the front end.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs1D, rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 rdE  in  5  destination register of the instruction in Execute.
REQ-007 memreadE  in  1  instruction in Execute is a load.
REQ-008 pcsrcE  in  1  taken branch or jump resolved in Execute.
REQ-009 md_startE  in  1  instruction in Execute is a multi-cycle op (mul/div).
REQ-010 mem_stall  in  1  data memory not ready; freeze the whole pipeline.
REQ-011 enF, enD, enE, enM, enW  out  1 each  enable for the Fetch/Decode/Execute/Memory/Writeback enable-flops.
REQ-012 flushD, flushE, flushM  out  1 each  synchronous clear for the D/E/M pipeline registers.
REQ-013 md_busy  out  1  multi-cycle op in progress (state BUSY).
REQ-014 md_done  out  1  single-cycle pulse in the cycle the multi-cycle op releases.
REQ-015 stall_cycles  out  CNT_W  count of cycles with enF=0 since reset.

Function
REQ-016 FSM states: RUN and BUSY; down-counter cnt sized to hold MD_CYCLES-1.
REQ-017 All outputs other than stall_cycles are combinational from state, cnt and inputs; there is no extra latency.
REQ-018 Default (RUN, no event): all en=1, all flush=0, md_busy=0, md_done=0.
REQ-019 Load-use condition (RUN only): memreadE=1, rdE!=0, and (rdE==rs1D or rdE==rs2D) -> enF=0, enD=0, flushE=1, all other enables=1.
REQ-020 Branch (RUN only): pcsrcE=1 -> flushD=1, flushE=1, all enables=1.
REQ-021 Multi-cycle start (RUN only): md_startE=1 -> enF=enD=enE=0, enM=enW=1, flushM=1; next state BUSY with cnt<=MD_CYCLES-1.
REQ-022 Priority in RUN: md_startE > pcsrcE > load-use; a lower-priority event is ignored in that cycle.
REQ-023 BUSY with cnt!=0: enF=enD=enE=0, enM=enW=1, flushM=1, flushD=flushE=0, md_busy=1; cnt decrements by 1 each cycle.
REQ-024 BUSY with cnt==0: release cycle; all en=1, all flush=0, md_busy=1, md_done=1; next state RUN.
REQ-025 In BUSY, pcsrcE, md_startE and the load-use condition are ignored; md_startE held high in the release cycle does not restart the op.
REQ-026 Total front-end stall per multi-cycle op is exactly MD_CYCLES cycles (the start cycle plus MD_CYCLES-1 BUSY cycles), followed by 1 release cycle.
REQ-027 mem_stall=1 overrides everything: all en=0, all flush=0, md_done=0; state and cnt hold; md_busy reflects the held state.
REQ-028 md_startE together with mem_stall=1 in RUN: no transition; the start is taken in the first cycle mem_stall=0.
REQ-029 stall_cycles increments in every cycle with enF=0, including mem_stall cycles, and saturates at all-ones without wrapping.

Reset
REQ-030 reset=1 at a rising edge: state<=RUN, cnt<=0, stall_cycles<=0.
REQ-031 While reset=1: all en=1, all flush=0, md_busy=0, md_done=0, regardless of other inputs.
REQ-032 Reset asserted during BUSY aborts the op; no md_done pulse is produced.

Verification
REQ-033 Load-use: memreadE=1, rdE=5, rs1D=5, one cycle -> enF=enD=0, flushE=1 for that cycle only, stall_cycles +1; repeat with rdE=0 -> no stall.
REQ-034 Branch: pcsrcE=1 with load-use also true -> flushD=flushE=1, enF=enD=1.
REQ-035 Multi-cycle, MD_CYCLES=8: md_startE held high -> enF=0 for 8 cycles, md_busy high for 8 cycles (7 BUSY stall cycles plus the release cycle), md_done pulses once in the 9th cycle, stall_cycles +8.
REQ-036 mem_stall: assert for 3 cycles in mid-BUSY -> all en=0, cnt frozen; release slips by exactly 3 cycles; stall_cycles +3 extra.
REQ-037 Reset mid-BUSY (cycle 4 of 8) -> next cycle RUN, all en=1, md_busy=0, no md_done, stall_cycles=0.
REQ-038 Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cycles stops at 4'hF.
